// File: rtl/divider_32_pkg.sv
// Shared constants, FSM encoding and the 32-bit two's-complement negator
// used by the signed divider.
package divider_32_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam logic [DIV_WIDTH-1:0] MOST_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Negating MOST_NEG yields 0x80000000, which callers read as the unsigned magnitude 2^31.
    function automatic logic [DIV_WIDTH-1:0] negate32(input logic [DIV_WIDTH-1:0] x);
        return ~x + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_step_32.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift {R,Q} left, trial-subtract |B| on a 33-bit path, keep or restore.
module div_step_32
    import divider_32_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic [DIV_WIDTH-1:0] quo_in,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic [DIV_WIDTH-1:0] quo_out
);

    logic [DIV_WIDTH:0]   rem_shift;
    logic [DIV_WIDTH:0]   diff;
    logic [DIV_WIDTH-1:0] rem_restore;
    logic                 diff_neg;

    always_comb begin
        rem_shift   = {rem_in, quo_in[DIV_WIDTH-1]};
        rem_restore = {rem_in[DIV_WIDTH-2:0], quo_in[DIV_WIDTH-1]};
        diff        = rem_shift + {1'b1, ~divisor} + (DIV_WIDTH + 1)'(1);
        diff_neg    = diff[DIV_WIDTH];
        rem_out     = diff_neg ? rem_restore : diff[DIV_WIDTH-1:0];
        quo_out     = {quo_in[DIV_WIDTH-2:0], ~diff_neg};
    end

endmodule

// File: rtl/divider_32.sv
// Signed 32-bit sequential divider: 32 restoring iterations on magnitudes,
// sign correction on the final edge, one-cycle completion strobe.
module divider_32
    import divider_32_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ctrl_DIV,
    input  logic [DIV_WIDTH-1:0] data_operandA,
    input  logic [DIV_WIDTH-1:0] data_operandB,
    output logic [DIV_WIDTH-1:0] data_result,
    output logic [DIV_WIDTH-1:0] data_remainder,
    output logic                 data_exception,
    output logic                 data_resultRDY
);

    div_state_e           state_q, state_d;
    logic [5:0]           count_q, count_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] bmag_q, bmag_d;
    logic                 q_sign_q, q_sign_d;
    logic                 r_sign_q, r_sign_d;
    logic                 exc_q, exc_d;
    logic [DIV_WIDTH-1:0] result_q, result_d;
    logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
    logic                 exception_q, exception_d;
    logic                 rdy_q, rdy_d;

    logic [DIV_WIDTH-1:0] a_abs, b_abs;
    logic [DIV_WIDTH-1:0] step_rem, step_quo;

    assign a_abs = data_operandA[DIV_WIDTH-1] ? negate32(data_operandA) : data_operandA;
    assign b_abs = data_operandB[DIV_WIDTH-1] ? negate32(data_operandB) : data_operandB;

    div_step_32 u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (bmag_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        bmag_d      = bmag_q;
        q_sign_d    = q_sign_q;
        r_sign_d    = r_sign_q;
        exc_d       = exc_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ctrl_DIV) begin
                    quo_d    = a_abs;
                    rem_d    = '0;
                    bmag_d   = b_abs;
                    q_sign_d = data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
                    r_sign_d = data_operandA[DIV_WIDTH-1];
                    exc_d    = (data_operandB == '0) ||
                               ((data_operandA == MOST_NEG) && (data_operandB == '1));
                    count_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Exceptional operands bypass the iterations and complete on the first edge.
                if (exc_q) begin
                    result_d    = '0;
                    remainder_d = '0;
                    exception_d = 1'b1;
                    rdy_d       = 1'b1;
                    state_d     = StDone;
                end else if (count_q == 6'(DIV_ITERS)) begin
                    result_d    = q_sign_q ? negate32(quo_q) : quo_q;
                    remainder_d = r_sign_q ? negate32(rem_q) : rem_q;
                    exception_d = 1'b0;
                    rdy_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + 6'd1;
                end
            end
            StDone: begin
                count_d = '0;
                state_d = StIdle;
            end
            default: begin
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            bmag_q      <= '0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            exc_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            bmag_q      <= bmag_d;
            q_sign_q    <= q_sign_d;
            r_sign_q    <= r_sign_d;
            exc_q       <= exc_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;

endmodule
